// File: rtl/j_gpuram_arb.sv
// GPU local RAM arbiter/sequencer.
// Shares one RAM port between the GPU core (priority) and the host bus. All
// RAM control is registered. Read data comes back with a one-cycle valid pulse,
// and a starvation counter guarantees that the host makes forward progress.
//
// Handshake (valid/ready): a requester drives req plus its fields (we, addr,
// wdata). The arbiter samples them on every rising edge. The edge that grants a
// request also raises that requester's ack for the following cycle, and that
// edge consumes the request. During the ack cycle the requester must either
// present its next request or drop req. Until ack, req and all fields are held.
module j_gpuram_arb #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          gpu_req,
  input  logic          gpu_we,
  input  logic [AW-1:0] gpu_addr,
  input  logic [DW-1:0] gpu_wdata,
  output logic          gpu_ack,
  output logic          gpu_rvalid,
  output logic [DW-1:0] gpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          ram_en,
  output logic          ram_wel,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          host_starved
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // Owner of the access currently on the RAM port. Together with ram_wel_q it
  // forms the read-return pipe stage, so each return routes to whoever issued it.
  owner_e        owner_q, owner_d;
  logic [3:0]    wait_q, wait_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_wel_q, ram_wel_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          gpu_ack_q, host_ack_q;
  logic          gpu_rvalid_q, host_rvalid_q, ret_gpu_d, ret_host_d;
  logic [DW-1:0] gpu_rdata_q, host_rdata_q;

  logic          gnt_gpu, gnt_host, gnt_any, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Arbitration, issue next-state, starvation counter and read-return routing
  always_comb begin
    gnt_host  = host_req & (~gpu_req | (wait_q == WAIT_MAX));
    gnt_gpu   = gpu_req & ~gnt_host;
    gnt_any   = gnt_gpu | gnt_host;
    sel_we    = gnt_host ? host_we    : gpu_we;
    sel_addr  = gnt_host ? host_addr  : gpu_addr;
    sel_wdata = gnt_host ? host_wdata : gpu_wdata;

    owner_d = OWN_NONE;
    if (gnt_gpu)       owner_d = OWN_GPU;
    else if (gnt_host) owner_d = OWN_HOST;

    ram_en_d  = gnt_any;
    ram_wel_d = ~(gnt_any & sel_we);
    ram_a_d   = gnt_any ? sel_addr  : ram_a_q;
    ram_din_d = gnt_any ? sel_wdata : ram_din_q;

    // The counter only grows while the host is actually waiting, and it
    // saturates so the forced host win stays armed until the host is served.
    wait_d = wait_q;
    if (!host_req || gnt_host)  wait_d = 4'd0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 4'd1;

    // A read on the port this cycle (owner set, write enable high) returns next cycle
    ret_gpu_d  = (owner_q == OWN_GPU)  & ram_wel_q;
    ret_host_d = (owner_q == OWN_HOST) & ram_wel_q;
  end

  // State, RAM control, acks and read returns; async reset drops any pending return
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      owner_q       <= OWN_NONE;
      wait_q        <= 4'd0;
      ram_en_q      <= 1'b0;
      ram_wel_q     <= 1'b1;
      ram_a_q       <= '0;
      ram_din_q     <= '0;
      gpu_ack_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      gpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      gpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      owner_q       <= owner_d;
      wait_q        <= wait_d;
      ram_en_q      <= ram_en_d;
      ram_wel_q     <= ram_wel_d;
      ram_a_q       <= ram_a_d;
      ram_din_q     <= ram_din_d;
      gpu_ack_q     <= gnt_gpu;
      host_ack_q    <= gnt_host;
      gpu_rvalid_q  <= ret_gpu_d;
      host_rvalid_q <= ret_host_d;
      if (ret_gpu_d)  gpu_rdata_q  <= ram_dout;
      if (ret_host_d) host_rdata_q <= ram_dout;
    end
  end

  assign gpu_ack      = gpu_ack_q;
  assign host_ack     = host_ack_q;
  assign gpu_rvalid   = gpu_rvalid_q;
  assign host_rvalid  = host_rvalid_q;
  assign gpu_rdata    = gpu_rdata_q;
  assign host_rdata   = host_rdata_q;
  assign ram_en       = ram_en_q;
  assign ram_wel      = ram_wel_q;
  assign ram_a        = ram_a_q;
  assign ram_din      = ram_din_q;
  assign host_starved = (wait_q == WAIT_MAX);

endmodule

// File: tb/tb_j_gpuram_arb.sv
// Testbench for j_gpuram_arb: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbiter and the RAM.
module tb_j_gpuram_arb;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          gpu_req = 0, gpu_we = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] gpu_addr = '0, host_addr = '0;
  logic [DW-1:0] gpu_wdata = '0, host_wdata = '0;
  logic          gpu_ack, gpu_rvalid, host_ack, host_rvalid;
  logic [DW-1:0] gpu_rdata, host_rdata;
  logic          ram_en, ram_wel, host_starved;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  j_gpuram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .sys_clk(sys_clk), .resetl(resetl),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_ack(gpu_ack), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_wel(ram_wel), .ram_a(ram_a), .ram_din(ram_din),
    .ram_dout(ram_dout), .host_starved(host_starved)
  );

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 0) return 32'hDEADBEEF;
    if (i == 5) return 32'h0000000A;
    if (i == 6) return 32'h0000000B;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM macro: chip select is active while clk is low, so it acts on the falling edge
  logic [DW-1:0] ram_mem [0:1023];
  bit ram_loaded = 0;
  always @(negedge sys_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] = init_word(i);
      ram_loaded = 1;
    end
    if (ram_en) begin
      if (!ram_wel) ram_mem[ram_a] = ram_din;
      else          ram_dout = ram_mem[ram_a];
    end
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] gold [0:1023];
  int            m_wait;
  bit            p_valid, p_host;
  logic [DW-1:0] p_data;
  bit            e_gack, e_hack, e_gval, e_hval, e_en, e_wel, e_starved;
  logic [DW-1:0] e_grd, e_hrd, e_din;
  logic [AW-1:0] e_a;

  task automatic model_reset();
    m_wait = 0; p_valid = 0; p_host = 0; p_data = '0;
    e_gack = 0; e_hack = 0; e_gval = 0; e_hval = 0; e_en = 0; e_wel = 1;
    e_starved = 0; e_grd = '0; e_hrd = '0; e_din = '0; e_a = '0;
  endtask

  // Decide the access that the next edge issues and advance one clock.
  // Afterwards the e_* variables describe what the DUT must show in the new cycle.
  task automatic tick();
    bit hw, gw, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    hw = 0; gw = 0; we = 0; a = '0; d = '0;
    if (resetl) begin
      hw = host_req && (!gpu_req || m_wait >= MAX_WAIT);
      gw = gpu_req && !hw;
    end
    e_gval = resetl && p_valid && !p_host;
    e_hval = resetl && p_valid && p_host;
    if (e_gval) e_grd = p_data;
    if (e_hval) e_hrd = p_data;
    p_valid = 0;
    e_gack = gw; e_hack = hw; e_en = gw || hw; e_wel = 1;
    if (gw || hw) begin
      we = hw ? host_we : gpu_we;
      a  = hw ? host_addr : gpu_addr;
      d  = hw ? host_wdata : gpu_wdata;
      e_a = a; e_din = d; e_wel = !we;
      if (we) gold[a] = d;
      else begin p_valid = 1; p_host = hw; p_data = gold[a]; end
    end
    if (!resetl || !host_req || hw) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    e_starved = (m_wait == MAX_WAIT);
    @(posedge sys_clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    gpu_req = 1; host_req = 1; gpu_we = 0; host_we = 0;
    gpu_addr = 10'h001; host_addr = 10'h002;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
      checks++; if (ram_wel !== 1'b1) begin errors++; $display("FAIL reset_ram_wel got=%b exp=1", ram_wel); end
      checks++; if ({gpu_ack, host_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got=%b exp=00", {gpu_ack, host_ack}); end
    end
    checks++; if ({gpu_rvalid, host_rvalid, host_starved} !== 3'b000 || gpu_rdata !== '0 || host_rdata !== '0 || ram_a !== '0 || ram_din !== '0) begin
      errors++; $display("FAIL reset_outputs rv=%b%b st=%b grd=%h hrd=%h a=%h din=%h exp all zero", gpu_rvalid, host_rvalid, host_starved, gpu_rdata, host_rdata, ram_a, ram_din);
    end
    resetl = 1;
    tick();
    checks++; if ({gpu_ack, host_ack} !== 2'b10) begin errors++; $display("FAIL first_grant got=%b exp=10", {gpu_ack, host_ack}); end
    gpu_req = 0;
    tick();
    checks++; if ({gpu_ack, host_ack} !== 2'b01) begin errors++; $display("FAIL second_grant got=%b exp=01", {gpu_ack, host_ack}); end
    host_req = 0;
    tick(); tick();
  endtask

  task automatic test_gpu_write_read();
    gpu_req = 1; gpu_we = 1; gpu_addr = 10'h3FF; gpu_wdata = 32'h12345678;
    tick();
    checks++; if (gpu_ack !== 1'b1 || ram_wel !== 1'b0 || ram_a !== 10'h3FF || ram_din !== 32'h12345678) begin
      errors++; $display("FAIL gpu_write_issue ack=%b wel=%b a=%h din=%h exp 1 0 3ff 12345678", gpu_ack, ram_wel, ram_a, ram_din);
    end
    gpu_we = 0;
    tick();
    checks++; if (gpu_ack !== 1'b1 || ram_wel !== 1'b1 || ram_en !== 1'b1) begin
      errors++; $display("FAIL gpu_read_issue ack=%b wel=%b en=%b exp 1 1 1", gpu_ack, ram_wel, ram_en);
    end
    gpu_req = 0;
    tick();
    checks++; if (gpu_rvalid !== 1'b1 || gpu_rdata !== 32'h12345678 || host_rvalid !== 1'b0) begin
      errors++; $display("FAIL gpu_raw_return rv=%b rd=%h hrv=%b exp 1 12345678 0", gpu_rvalid, gpu_rdata, host_rvalid);
    end
    tick();
    checks++; if (gpu_rvalid !== 1'b0 || gpu_rdata !== 32'h12345678) begin
      errors++; $display("FAIL gpu_rdata_hold rv=%b rd=%h exp 0 12345678", gpu_rvalid, gpu_rdata);
    end
  endtask

  task automatic test_host_read();
    host_req = 1; host_we = 0; host_addr = 10'h000;
    tick();
    checks++; if (host_ack !== 1'b1 || host_rvalid !== 1'b0) begin errors++; $display("FAIL host_ack got ack=%b rv=%b exp 1 0", host_ack, host_rvalid); end
    host_req = 0;
    tick();
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEADBEEF || gpu_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_read rv=%b rd=%h grv=%b exp 1 deadbeef 0", host_rvalid, host_rdata, gpu_rvalid);
    end
  endtask

  task automatic test_starvation();
    gpu_req = 1; gpu_we = 0; gpu_addr = 10'(32'h100 + $urandom_range(0, 31));
    host_req = 1; host_we = 0; host_addr = 10'h007;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) begin
        checks++; if (host_starved !== 1'b1 || host_ack !== 1'b0) begin errors++; $display("FAIL starve_flag k=%0d st=%b hack=%b exp 1 0", k, host_starved, host_ack); end
      end
      if (k == 5) begin
        checks++; if (host_ack !== 1'b1 || gpu_ack !== 1'b0 || host_starved !== 1'b0) begin
          errors++; $display("FAIL starve_grant k=%0d hack=%b gack=%b st=%b exp 1 0 0", k, host_ack, gpu_ack, host_starved);
        end
      end
      if (k == 6) begin
        checks++; if (gpu_ack !== 1'b1 || host_rvalid !== 1'b1 || host_rdata !== e_hrd) begin
          errors++; $display("FAIL starve_resume gack=%b hrv=%b hrd=%h exp 1 1 %h", gpu_ack, host_rvalid, host_rdata, e_hrd);
        end
      end
      checks++; if (gpu_rvalid !== e_gval || (e_gval && gpu_rdata !== e_grd)) begin
        errors++; $display("FAIL starve_gpu_ret k=%0d rv=%b rd=%h exp %b %h", k, gpu_rvalid, gpu_rdata, e_gval, e_grd);
      end
      if (host_ack) host_req = 0;
      if (gpu_ack) gpu_addr = gpu_addr + 10'd1;
    end
    gpu_req = 0; host_req = 0;
    tick(); tick();
  endtask

  task automatic test_interleave();
    gpu_req = 1; gpu_we = 0; gpu_addr = 10'd5;
    host_req = 1; host_we = 0; host_addr = 10'd6;
    tick();
    checks++; if ({gpu_ack, host_ack} !== 2'b10) begin errors++; $display("FAIL il_grant1 got=%b exp=10", {gpu_ack, host_ack}); end
    gpu_req = 0;
    tick();
    checks++; if ({gpu_ack, host_ack} !== 2'b01 || gpu_rvalid !== 1'b1 || host_rvalid !== 1'b0 || gpu_rdata !== 32'hA) begin
      errors++; $display("FAIL il_cycle2 ack=%b%b rv=%b%b grd=%h exp 01 10 0000000a", gpu_ack, host_ack, gpu_rvalid, host_rvalid, gpu_rdata);
    end
    host_req = 0;
    tick();
    checks++; if (host_rvalid !== 1'b1 || gpu_rvalid !== 1'b0 || host_rdata !== 32'hB || gpu_rdata !== 32'hA) begin
      errors++; $display("FAIL il_cycle3 rv=%b%b hrd=%h grd=%h exp 01 0000000b 0000000a", gpu_rvalid, host_rvalid, host_rdata, gpu_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    host_req = 1; host_we = 0; host_addr = 10'h010;
    tick();
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rmr_ack got=%b exp=1", host_ack); end
    resetl = 0; host_req = 0;
    model_reset();
    #1;
    checks++; if ({ram_en, ram_wel, host_ack, ram_a} !== {3'b010, 10'h000} || host_rdata !== '0 || gpu_rdata !== '0) begin
      errors++; $display("FAIL rmr_immediate en=%b wel=%b ack=%b a=%h hrd=%h grd=%h exp 0 1 0 000 0 0", ram_en, ram_wel, host_ack, ram_a, host_rdata, gpu_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_no_rvalid cyc=%0d got=%b exp=0", i, host_rvalid); end
    end
    resetl = 1;
    tick();
  endtask

  task automatic test_random();
    bit g_pend, h_pend;
    g_pend = 0; h_pend = 0;
    for (int n = 0; n < 600; n++) begin
      if (!g_pend) begin
        gpu_req = ($urandom_range(0, 3) != 0);
        gpu_we = $urandom_range(0, 1) == 1; gpu_addr = 10'($urandom_range(0, 15)); gpu_wdata = $urandom;
      end
      if (!h_pend) begin
        host_req = ($urandom_range(0, 2) == 0);
        host_we = $urandom_range(0, 1) == 1; host_addr = 10'($urandom_range(0, 15)); host_wdata = $urandom;
      end
      g_pend = gpu_req; h_pend = host_req;
      tick();
      checks++; if ({gpu_ack, host_ack} !== {e_gack, e_hack}) begin errors++; $display("FAIL rnd_ack n=%0d got=%b%b exp=%b%b", n, gpu_ack, host_ack, e_gack, e_hack); end
      checks++; if ({ram_en, ram_wel} !== {e_en, e_wel}) begin errors++; $display("FAIL rnd_ctl n=%0d got en=%b wel=%b exp %b %b", n, ram_en, ram_wel, e_en, e_wel); end
      checks++; if (ram_a !== e_a || ram_din !== e_din) begin errors++; $display("FAIL rnd_addr_data n=%0d got %h %h exp %h %h", n, ram_a, ram_din, e_a, e_din); end
      checks++; if ({gpu_rvalid, host_rvalid} !== {e_gval, e_hval}) begin errors++; $display("FAIL rnd_rvalid n=%0d got=%b%b exp=%b%b", n, gpu_rvalid, host_rvalid, e_gval, e_hval); end
      checks++; if (gpu_rdata !== e_grd || host_rdata !== e_hrd) begin errors++; $display("FAIL rnd_rdata n=%0d got %h %h exp %h %h", n, gpu_rdata, host_rdata, e_grd, e_hrd); end
      checks++; if (host_starved !== e_starved) begin errors++; $display("FAIL rnd_starved n=%0d got=%b exp=%b", n, host_starved, e_starved); end
      checks++; if (!ram_wel && !ram_en) begin errors++; $display("FAIL rnd_wel_without_en n=%0d wel=%b en=%b", n, ram_wel, ram_en); end
      if (gpu_ack) g_pend = 0;
      if (host_ack) h_pend = 0;
    end
    gpu_req = 0; host_req = 0;
    tick(); tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1024; i++) gold[i] = init_word(i);
    model_reset();
    test_reset();
    test_gpu_write_read();
    test_host_read();
    test_starvation();
    test_interleave();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
